// File: rtl/down_timer_8bit_pkg.sv
// Shared types and default widths for the down-counting interval timer.
package down_timer_8bit_pkg;
    localparam int DT_WIDTH = 8;
    localparam int DT_PW    = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;
endpackage

// File: rtl/down_timer_8bit_prescaler_tick.sv
// Prescaler: produces one tick every P+1 enabled cycles; clear restarts the phase at zero.
module prescaler_tick #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          enable,
    input  logic [PW-1:0] p_val,
    output logic          tick
);
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    assign tick = enable && !clear && (pre_q == p_val);

    always_comb begin
        pre_d = pre_q;
        if (clear) begin
            pre_d = '0;
        end else if (enable) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
endmodule

// File: rtl/down_timer_8bit.sv
// Loadable down-counting timer with prescaler, one-shot or auto-reload, and terminal-count pulse.
module down_timer_8bit
    import down_timer_8bit_pkg::*;
#(
    parameter int WIDTH = DT_WIDTH,
    parameter int PW    = DT_PW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] load_value,
    input  logic [PW-1:0]    prescale,
    input  logic             auto_reload,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc_pulse,
    output logic             done
);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [PW-1:0]    p_q, p_d;
    logic             mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic             start_ok;
    logic             pre_clear;
    logic             pre_en;
    logic             tick;

    assign start_ok  = start && !stop;
    assign pre_en    = (state_q == ST_RUN);
    assign pre_clear = start_ok || stop || (state_q == ST_IDLE);

    prescaler_tick #(.PW(PW)) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (pre_clear),
        .enable (pre_en),
        .p_val  (p_q),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        n_d     = n_q;
        p_d     = p_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        tc_d    = 1'b0;
        done_d  = done_q;

        if (start_ok) begin
            if (load_value == '0) begin
                // A zero interval terminates immediately without entering RUN.
                tc_d    = 1'b1;
                done_d  = !auto_reload;
                count_d = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end else begin
                n_d     = load_value;
                p_d     = prescale;
                mode_d  = auto_reload;
                count_d = load_value;
                done_d  = 1'b0;
                busy_d  = 1'b1;
                state_d = ST_RUN;
            end
        end else if (state_q == ST_RUN) begin
            if (stop) begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end else if (tick) begin
                if (count_q > CNT_ONE) begin
                    count_d = count_q - CNT_ONE;
                end else if (count_q == CNT_ONE) begin
                    tc_d = 1'b1;
                    if (mode_q) begin
                        count_d = n_q;
                    end else begin
                        count_d = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            n_q     <= '0;
            p_q     <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            n_q     <= n_d;
            p_q     <= p_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    assign count    = count_q;
    assign busy     = busy_q;
    assign tc_pulse = tc_q;
    assign done     = done_q;
endmodule
